lcd_screen_sequencer: RTL

LCD_SCREEN_SEQUENCER -- requirements
Module: lcd_screen_sequencer

---
 rtl/lcd_screen_sequencer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/lcd_screen_sequencer.sv
// Streams a 32-char two-line buffer to an LCD driver as 34 items (0x80, 16 chars, 0xC0, 16 chars).
// One registered strobe per item, issued only when lcd_busy=0; items with no busy response are re-sent.
module lcd_screen_sequencer #(
  parameter bit AUTO_START = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       buf_we,
  input  logic [4:0] buf_addr,
  input  logic [7:0] buf_wdata,
  input  logic       refresh,
  output logic [7:0] lcd_data,
  output logic       lcd_do_init,
  output logic       lcd_wr_cmd,
  output logic       lcd_wr_char,
  input  logic       lcd_initialized,
  input  logic       lcd_busy,
  output logic       seq_busy,
  output logic       seq_done
);
  typedef enum logic [2:0] {INIT, READY, ISSUE, WAIT_ACK, WAIT_DONE, NEXT} state_e;
  localparam logic [5:0] LAST_ITEM = 6'd33;

  state_e     state_q;
  logic       pending_q;
  logic [5:0] idx_q;
  logic [1:0] ack_cnt_q;
  logic [7:0] data_q;
  logic       do_init_q;
  logic       wr_cmd_q;
  logic       wr_char_q;
  logic       busy_q;
  logic       done_q;
  logic [7:0] buf_q [32];

  logic       item_is_cmd;
  logic [4:0] buf_rd;
  logic [7:0] item_byte;

  // Line 2 characters sit two items past their buffer index; the 5-bit wrap handles items 32/33.
  always_comb begin
    item_is_cmd = (idx_q == 6'd0) || (idx_q == 6'd17);
    buf_rd      = (idx_q < 6'd17) ? (idx_q[4:0] - 5'd1) : (idx_q[4:0] - 5'd2);
    if (idx_q == 6'd0)       item_byte = 8'h80;
    else if (idx_q == 6'd17) item_byte = 8'hC0;
    else                     item_byte = buf_q[buf_rd];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) buf_q[i] <= 8'h20;
    end else if (buf_we) begin
      buf_q[buf_addr] <= buf_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= INIT;
      pending_q <= AUTO_START;
      idx_q     <= 6'd0;
      ack_cnt_q <= 2'd0;
      data_q    <= 8'h00;
      do_init_q <= 1'b0;
      wr_cmd_q  <= 1'b0;
      wr_char_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      wr_cmd_q  <= 1'b0;
      wr_char_q <= 1'b0;
      done_q    <= 1'b0;
      if (refresh && busy_q) pending_q <= 1'b1;
      // Losing the driver mid-run aborts silently and schedules a fresh refresh.
      if (!lcd_initialized && state_q != INIT) begin
        state_q   <= INIT;
        busy_q    <= 1'b0;
        pending_q <= 1'b1;
      end else begin
        case (state_q)
          INIT: begin
            if (lcd_initialized) begin
              do_init_q <= 1'b0;
              state_q   <= READY;
              if (AUTO_START) pending_q <= 1'b1;
            end else begin
              do_init_q <= 1'b1;
            end
          end
          READY: begin
            if (refresh || pending_q) begin
              pending_q <= 1'b0;
              busy_q    <= 1'b1;
              idx_q     <= 6'd0;
              state_q   <= ISSUE;
            end
          end
          ISSUE: begin
            if (!lcd_busy) begin
              data_q    <= item_byte;
              wr_cmd_q  <= item_is_cmd;
              wr_char_q <= !item_is_cmd;
              ack_cnt_q <= 2'd0;
              state_q   <= WAIT_ACK;
            end
          end
          WAIT_ACK: begin
            if (lcd_busy)                state_q   <= WAIT_DONE;
            else if (ack_cnt_q == 2'd3)  state_q   <= ISSUE;
            else                         ack_cnt_q <= ack_cnt_q + 2'd1;
          end
          WAIT_DONE: begin
            if (!lcd_busy) state_q <= NEXT;
          end
          NEXT: begin
            if (idx_q == LAST_ITEM) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= READY;
            end else begin
              idx_q   <= idx_q + 6'd1;
              state_q <= ISSUE;
            end
          end
          default: state_q <= INIT;
        endcase
      end
    end
  end

  assign lcd_data    = data_q;
  assign lcd_do_init = do_init_q;
  assign lcd_wr_cmd  = wr_cmd_q;
  assign lcd_wr_char = wr_char_q;
  assign seq_busy    = busy_q;
  assign seq_done    = done_q;
endmodule
